// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream carrying one packed pipeline-stage bundle between two stages.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface pipe_stage_reg_if #(
  parameter int W = 74
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register: registered valid/ready stage with an optional
// 2-entry skid buffer and a synchronous flush of everything it holds.
module pipe_stage_reg #(
  parameter int           W              = 74,
  parameter bit           SKID           = 1'b1,
  parameter logic [W-1:0] RESET_VAL      = '0,
  parameter bit           CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master down,
  output logic [1:0]       occupancy
);

  logic         main_valid;
  logic         main_valid_nxt;
  logic [W-1:0] main_data;
  logic [W-1:0] main_data_nxt;
  logic         skid_valid;
  logic         skid_valid_nxt;
  logic [W-1:0] skid_data;
  logic         skid_load;
  logic         ready;
  logic         accept;
  logic         issue;

  // With a skid entry, ready comes straight from a flop, so out_ready never
  // reaches in_ready combinationally; without one, ready looks through.
  assign ready  = SKID ? ~skid_valid : (down.ready | ~main_valid);
  assign accept = up.valid & ready;
  assign issue  = main_valid & down.ready;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through
    // the branches below leaves one unassigned and infers a latch.
    main_valid_nxt = main_valid;
    main_data_nxt  = main_data;
    skid_valid_nxt = skid_valid;
    skid_load      = 1'b0;

    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_data_nxt = RESET_VAL;
      end
    end else if (!main_valid) begin
      if (accept) begin
        main_valid_nxt = 1'b1;
        main_data_nxt  = up.data;
      end
    end else if (issue) begin
      if (skid_valid) begin
        main_data_nxt  = skid_data;
        skid_valid_nxt = 1'b0;
      end else if (accept) begin
        main_data_nxt  = up.data;
      end else begin
        main_valid_nxt = 1'b0;
      end
    end else if (SKID && accept) begin
      skid_valid_nxt = 1'b1;
      skid_load      = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= RESET_VAL;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_nxt;
      main_data  <= main_data_nxt;
      skid_valid <= skid_valid_nxt;
    end
  end

  // NOTE: the skid payload carries no reset; it is only read while
  // skid_valid is set, and skid_valid itself is reset.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_data <= up.data;
    end
  end

  assign up.ready   = ready;
  assign down.valid = main_valid;
  assign down.data  = main_data;
  assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: one skid instance (W=74) and one
// single-register instance (W=16), both compared against FIFO queue models.
module tb_pipe_stage_reg;

  localparam int WA = 74;
  localparam int WB = 16;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       a_flush = 1'b0;
  logic       b_flush = 1'b0;
  logic [1:0] a_occ;
  logic [1:0] b_occ;

  pipe_stage_reg_if #(.W(WA)) a_up ();
  pipe_stage_reg_if #(.W(WA)) a_down ();
  pipe_stage_reg_if #(.W(WB)) b_up ();
  pipe_stage_reg_if #(.W(WB)) b_down ();

  pipe_stage_reg #(.W(WA), .SKID(1'b1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (a_flush),
    .up        (a_up),
    .down      (a_down),
    .occupancy (a_occ)
  );

  pipe_stage_reg #(.W(WB), .SKID(1'b0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (b_flush),
    .up        (b_up),
    .down      (b_down),
    .occupancy (b_occ)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference models: the entries each block holds, oldest first.
  logic [WA-1:0] qa[$];
  logic [WB-1:0] qb[$];
  bit            a_known = 1'b1;  // queue empty and out_data must be RESET_VAL
  bit            b_known = 1'b1;
  bit            a_acc;
  bit            b_acc;

  task automatic chk(input string tag, input logic [WA-1:0] obs, input logic [WA-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_models();
    chk("a_out_valid", WA'(a_down.valid), WA'(qa.size() != 0));
    chk("a_occupancy", WA'(a_occ), WA'(qa.size()));
    chk("a_in_ready", WA'(a_up.ready), WA'(qa.size() < 2));
    if (qa.size() != 0) chk("a_out_data", a_down.data, qa[0]);
    else if (a_known)   chk("a_out_data_reset", a_down.data, '0);
    chk("b_out_valid", WA'(b_down.valid), WA'(qb.size() != 0));
    chk("b_occupancy", WA'(b_occ), WA'(qb.size()));
    chk("b_in_ready", WA'(b_up.ready), WA'(qb.size() == 0 || b_down.ready));
    if (qb.size() != 0) chk("b_out_data", WA'(b_down.data), WA'(qb[0]));
    else if (b_known)   chk("b_out_data_reset", WA'(b_down.data), '0);
  endtask

  // Called just after a falling edge with inputs already driven; checks the
  // outputs, advances both models across the next rising edge.
  task automatic step();
    bit a_iss;
    bit b_iss;
    #1;
    check_models();
    a_acc = a_up.valid && (qa.size() < 2);
    a_iss = (qa.size() != 0) && a_down.ready;
    b_acc = b_up.valid && (qb.size() == 0 || b_down.ready);
    b_iss = (qb.size() != 0) && b_down.ready;
    if (a_flush) begin
      qa.delete();
      a_known = 1'b1;
    end else begin
      if (a_iss) begin
        void'(qa.pop_front());
        a_known = 1'b0;
      end
      if (a_acc) qa.push_back(a_up.data);
    end
    if (b_flush) begin
      qb.delete();
      b_known = 1'b1;
    end else begin
      if (b_iss) begin
        void'(qb.pop_front());
        b_known = 1'b0;
      end
      if (b_acc) qb.push_back(b_up.data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pull reset mid-cycle and check the outputs clear before the next edge.
  task automatic mid_reset();
    #2 reset = 1'b0;
    #1;
    chk("a_async_valid", WA'(a_down.valid), '0);
    chk("a_async_occ", WA'(a_occ), '0);
    chk("a_async_data", a_down.data, '0);
    chk("b_async_valid", WA'(b_down.valid), '0);
    chk("b_async_occ", WA'(b_occ), '0);
    chk("b_async_data", WA'(b_down.data), '0);
    qa.delete();
    qb.delete();
    a_known = 1'b1;
    b_known = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int a_seq;
    int b_seq;
    int sent;

    a_up.valid   = 1'b0;
    a_up.data    = '0;
    a_down.ready = 1'b0;
    b_up.valid   = 1'b0;
    b_up.data    = '0;
    b_down.ready = 1'b0;

    // Reset state
    #1;
    check_models();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Continuous stream through the skid instance
    a_seq = 1;
    repeat (20) begin
      a_up.valid   = 1'b1;
      a_up.data    = WA'(a_seq);
      a_down.ready = 1'b1;
      step();
      if (a_acc) a_seq++;
    end
    a_up.valid = 1'b0;
    repeat (2) step();

    // Backpressure: A, B, C with the consumer stalled for four cycles
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      a_up.valid   = (sent < 3);
      a_up.data    = WA'(100 + sent);
      a_down.ready = (c >= 4);
      step();
      if (a_acc) sent++;
    end

    // Flush with both entries full and a new payload offered
    a_down.ready = 1'b0;
    a_up.valid   = 1'b1;
    a_up.data    = WA'(200);
    step();
    a_up.data    = WA'(201);
    step();
    a_up.data    = WA'(202);
    a_flush      = 1'b1;
    step();
    a_flush      = 1'b0;
    a_up.valid   = 1'b0;
    a_down.ready = 1'b1;
    repeat (3) step();

    // Flush held for several cycles while upstream keeps offering
    a_flush    = 1'b1;
    a_up.valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      a_up.data = WA'(300 + c);
      step();
    end
    a_flush    = 1'b0;
    a_up.valid = 1'b0;
    step();

    // Flush coinciding with an issue
    a_down.ready = 1'b0;
    a_up.valid   = 1'b1;
    a_up.data    = WA'(400);
    step();
    a_up.valid   = 1'b0;
    a_down.ready = 1'b1;
    a_flush      = 1'b1;
    step();
    a_flush      = 1'b0;
    repeat (3) step();

    // Reset in the middle of traffic
    a_down.ready = 1'b0;
    a_up.valid   = 1'b1;
    a_up.data    = WA'(500);
    b_up.valid   = 1'b1;
    b_up.data    = WB'(16'h0500);
    step();
    a_up.data    = WA'(501);
    step();
    mid_reset();
    a_up.valid   = 1'b1;
    a_up.data    = WA'(600);
    a_down.ready = 1'b1;
    b_up.valid   = 1'b0;
    step();
    a_up.valid   = 1'b0;
    repeat (2) step();

    // Single-register instance: continuous input, consumer alternating
    b_seq = 1;
    for (int c = 0; c < 16; c++) begin
      b_up.valid   = 1'b1;
      b_up.data    = WB'(b_seq);
      b_down.ready = (c % 2 == 0);
      step();
      if (b_acc) b_seq++;
    end
    b_up.valid   = 1'b0;
    b_down.ready = 1'b1;
    repeat (2) step();

    // Random traffic on both instances
    for (int c = 0; c < 400; c++) begin
      a_up.valid   = ($urandom_range(0, 3) != 0);
      a_up.data    = WA'({$urandom(), $urandom(), $urandom()});
      a_down.ready = ($urandom_range(0, 3) != 0);
      a_flush      = ($urandom_range(0, 19) == 0);
      b_up.valid   = ($urandom_range(0, 3) != 0);
      b_up.data    = WB'($urandom());
      b_down.ready = ($urandom_range(0, 2) != 0);
      b_flush      = ($urandom_range(0, 19) == 0);
      step();
    end
    a_flush    = 1'b0;
    b_flush    = 1'b0;
    a_up.valid = 1'b0;
    b_up.valid = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
